// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the RAM access scheduler.
package mem_sched_pkg;

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  localparam logic       REGION_INSTR = 1'b0;
  localparam logic       REGION_DATA  = 1'b1;
  localparam logic [3:0] BE_ALL       = 4'hF;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_lat_tracker.sv
// Tracks the single outstanding RAM read: latency countdown, owner tag,
// rdata capture and the one-cycle rvalid pulse to the owning port.
module mem_lat_tracker
  import mem_sched_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_start,
  input  owner_e            rd_owner,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              rd_done,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  localparam int              LAT_W    = cnt_w(RAM_LAT);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RAM_LAT - 1);

  state_e            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  owner_e            owner;

  assign busy    = (state == RD_WAIT);
  assign rd_done = busy && (lat_cnt == '0);

  // Next state: a read granted on the completion cycle keeps us in RD_WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_start) state_nxt = RD_WAIT;
      RD_WAIT: if (rd_done)  state_nxt = rd_start ? RD_WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any read in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latency countdown and owner tag, reloaded on every read grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= '0;
      owner   <= OWN_IF;
    end else if (rd_start) begin
      lat_cnt <= LAT_INIT;
      owner   <= rd_owner;
    end else if (busy && !rd_done) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  // Capture RAM data for the owner and pulse its rvalid one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= rd_done && (owner == OWN_IF);
      d_rvalid  <= rd_done && (owner == OWN_D);
      if (rd_done && owner == OWN_IF) if_rdata <= mem_rdata;
      if (rd_done && owner == OWN_D)  d_rdata  <= mem_rdata;
    end
  end

endmodule

// File: rtl/mem_access_sched.sv
// Arbitrates the shared RAM between instruction fetch and load/store.
// Data wins by default; a starvation counter forces fetch through after
// MAX_DBURST consecutive data grants.
module mem_access_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = 1,
  parameter int MAX_DBURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-2:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-2:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_stall
);

  localparam int SC_W = $clog2(MAX_DBURST + 1);

  logic [SC_W-1:0] starve_cnt;
  logic            busy, rd_done, can_gnt, force_if, d_win, if_win;
  logic            st_nop, rd_start;
  owner_e          rd_owner;

  // Grants only when no read is pending, or on the cycle the pending one completes.
  assign can_gnt  = reset && (!busy || rd_done);
  assign force_if = (starve_cnt == SC_W'(MAX_DBURST));
  assign d_win    = d_req && !(if_req && force_if);
  assign if_win   = if_req && !d_win;
  assign if_gnt   = can_gnt && if_win;
  assign d_gnt    = can_gnt && d_win;

  assign st_nop   = d_we && (d_be == 4'h0);
  assign rd_start = if_gnt || (d_gnt && !d_we);
  assign rd_owner = if_gnt ? OWN_IF : OWN_D;

  // RAM command mux driven from the winning port; a zero-mask store touches nothing.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = BE_ALL;
      mem_addr = {REGION_INSTR, if_addr};
    end else if (d_gnt && !st_nop) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_we ? d_be : BE_ALL;
      mem_addr  = {REGION_DATA, d_addr};
      mem_wdata = d_we ? d_wdata : '0;
    end
  end

  assign core_stall = reset && ((if_req && !if_gnt) || (d_req && !d_gnt) || busy);

  // Count data grants that bypass a waiting fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   starve_cnt <= '0;
    else if (!if_req || if_gnt)   starve_cnt <= '0;
    else if (d_gnt && !force_if)  starve_cnt <= starve_cnt + SC_W'(1);
  end

  mem_lat_tracker #(
    .DATA_W  (DATA_W),
    .RAM_LAT (RAM_LAT)
  ) u_trk (
    .clk       (clk),
    .reset     (reset),
    .rd_start  (rd_start),
    .rd_owner  (rd_owner),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .rd_done   (rd_done),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata)
  );

endmodule

// File: tb/tb_mem_access_sched.sv
// Scoreboarded bench: stimulus pushes expected read data, a monitor pops on rvalid.
// A second instance with RAM_LAT=3 covers reset during an in-flight read.
module tb_mem_access_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [11:0] if_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, core_stall;
  logic [3:0]  mem_be;
  logic [12:0] mem_addr;

  // second instance (RAM_LAT=3), fetch port only
  logic        if_req3;
  logic [11:0] if_addr3;
  logic        d_req3 = 1'b0, d_we3 = 1'b0;
  logic [11:0] d_addr3 = '0;
  logic [31:0] d_wdata3 = '0;
  logic [3:0]  d_be3 = '0;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, core_stall3;
  logic [31:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_be3;
  logic [12:0] mem_addr3;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];

  always #5 clk = ~clk;

  mem_access_sched #(.ADDR_W(13), .DATA_W(32), .RAM_LAT(1), .MAX_DBURST(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .core_stall(core_stall));

  mem_access_sched #(.ADDR_W(13), .DATA_W(32), .RAM_LAT(3), .MAX_DBURST(4)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_be(d_be3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .core_stall(core_stall3));

  // RAM model, latency 1, byte-masked writes
  logic [31:0] ram [0:8191];
  logic [31:0] rd_q;
  assign mem_rdata = rd_q;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_en && !mem_we) rd_q <= ram[mem_addr];
  end

  // Latency-3 RAM for dut3: word content equals its address
  logic [31:0] p3 [3];
  assign mem_rdata3 = p3[2];
  always @(posedge clk) begin
    p3[0] <= mem_en3 ? {19'h0, mem_addr3} : 32'hDEAD_BEEF;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (if_rvalid) begin
      if (exp_if.size() == 0) chk("if_rvalid_unexpected", 1, 0);
      else chk("if_rdata", if_rdata, exp_if.pop_front());
    end
    if (d_rvalid) begin
      if (exp_d.size() == 0) chk("d_rvalid_unexpected", 1, 0);
      else chk("d_rdata", d_rdata, exp_d.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nd;
    bit  got_if, stall_all;
    logic [3:0] rv;
    for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
    ram[13'h0004] = 32'h00500093;
    ram[13'h1010] = 32'h11223344;
    ram[13'h1020] = 32'h55667788;
    reset = 1'b0; if_req = 1'b1; if_addr = 12'h004;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    if_req3 = 0; if_addr3 = 0;

    // 1: outputs quiet in reset, fetch granted on the first active cycle
    exp_if.push_back(32'h00500093);
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outputs_zero",
        {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we,
         mem_be, mem_addr, mem_wdata, core_stall}, 128'h0);
    @(negedge clk); reset = 1'b1;
    #2;
    chk("release_if_gnt", {if_gnt, mem_en, d_gnt}, 3'b110);
    chk("release_mem_addr", mem_addr, 13'h0004);
    @(negedge clk); if_req = 0;
    repeat (4) @(negedge clk);

    // 2: fetch latency t+2
    if_req = 1; if_addr = 12'h004; exp_if.push_back(32'h00500093);
    #2 chk("t2_if_gnt", if_gnt, 1);
    @(negedge clk); if_req = 0;
    chk("t2_rvalid_t1", if_rvalid, 0);
    @(negedge clk);
    chk("t2_rvalid_t2", {if_rvalid, if_rdata}, {1'b1, 32'h00500093});
    repeat (3) @(negedge clk);

    // 3: data beats fetch; fetch granted once the load completes
    d_req = 1; d_we = 0; d_addr = 12'h010; if_req = 1; if_addr = 12'h004;
    exp_d.push_back(32'h11223344); exp_if.push_back(32'h00500093);
    #2;
    chk("t3_d_first", {d_gnt, if_gnt, core_stall}, 3'b101);
    chk("t3_mem_addr", mem_addr, 13'h1010);
    @(negedge clk); d_req = 0;
    got_if = 0; stall_all = 1;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (!core_stall) stall_all = 0;
      if (if_gnt) begin got_if = 1; break; end
      @(negedge clk);
    end
    chk("t3_if_gnt_follows", got_if, 1);
    chk("t3_stall_throughout", stall_all, 1);
    @(negedge clk); if_req = 0;
    repeat (4) @(negedge clk);

    // 4: starvation bound, 4 stores then fetch forced
    if_req = 1; if_addr = 12'h004; exp_if.push_back(32'h00500093);
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 12'h030; d_wdata = 32'h1000_0000;
    nd = 0; got_if = 0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (d_gnt) begin
        nd++;
        if (nd == 1) chk("t4_store_we", {mem_en, mem_we, mem_be}, 6'b11_1111);
      end
      if (if_gnt) begin got_if = 1; d_req = 0; break; end
      @(negedge clk);
      d_addr = d_addr + 12'h1; d_wdata = d_wdata + 32'h1;
    end
    chk("t4_d_grants", nd, 4);
    chk("t4_if_forced", got_if, 1);
    @(negedge clk); if_req = 0;
    #2 chk("t4_starve_clear", dut.starve_cnt, 0);
    repeat (4) @(negedge clk);

    // 5: partial store, readback, zero-mask store is a no-op
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 12'h020; d_wdata = 32'hAABBCCDD;
    #2;
    chk("t5_store_cmd", {d_gnt, mem_en, mem_we, mem_be}, 7'b111_0011);
    chk("t5_store_addr", {mem_addr, mem_wdata}, {13'h1020, 32'hAABBCCDD});
    @(negedge clk); d_we = 0; exp_d.push_back(32'h5566CCDD);
    #2 chk("t5_load_cmd", {d_gnt, mem_en, mem_we, mem_be}, 7'b110_1111);
    @(negedge clk); d_req = 0;
    repeat (4) @(negedge clk);
    d_req = 1; d_we = 1; d_be = 4'h0; d_wdata = 32'hFFFFFFFF;
    #2 chk("t5_nop_store", {d_gnt, mem_en, mem_we}, 3'b100);
    @(negedge clk); d_we = 0; exp_d.push_back(32'h5566CCDD);
    #2 chk("t5_reload_gnt", d_gnt, 1);
    @(negedge clk); d_req = 0;
    repeat (4) @(negedge clk);

    // 6: reset while a latency-3 read is in flight
    if_req3 = 1; if_addr3 = 12'h005;
    #2 chk("t6_gnt", if_gnt3, 1);
    @(negedge clk); if_req3 = 0;
    #2 chk("t6_stall_wait", core_stall3, 1);
    @(negedge clk); reset = 0;
    #2 chk("t6_in_reset", {if_rvalid3, core_stall3, if_gnt3}, 3'b000);
    @(negedge clk); reset = 1;
    rv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if_rvalid3) rv[0] = 1'b1;
    end
    chk("t6_no_rvalid_after_reset", rv[0], 0);
    chk("t6_idle", {core_stall3, if_rdata3}, 33'h0);
    if_req3 = 1; if_addr3 = 12'h006;
    #2 chk("t6_regrant", if_gnt3, 1);
    @(negedge clk); if_req3 = 0;
    rv[0] = if_rvalid3;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      rv[i] = if_rvalid3;
    end
    chk("t6_lat3_timing", rv, 4'b1000);
    chk("t6_lat3_data", if_rdata3, 32'h0000_0006);
    repeat (3) @(negedge clk);

    chk("sb_if_drained", exp_if.size(), 0);
    chk("sb_d_drained", exp_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
